dogx_sample_buffer: RTL and testbench
=====================================

DOGX_SAMPLE_BUFFER -- requirements
Module: dogx_sample_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 4..32.
REQ-002 Parameter DW, default 12, stored word width ({alpha, 11-bit sample}); SHALL be fixed at 12.
REQ-003 CLK_24M  in  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserting it SHALL clear all state immediately.
REQ-005 enable_sampling_3M  in  1  one-cycle-in-8 sample strobe from the converter clock-enable generator.
REQ-006 sample_in  in  11  converter output word, two's complement.
REQ-007 alpha_in  in  1  channel-select flag in effect for sample_in.
REQ-008 capture_en  in  1  level; high enables sample capture.
REQ-009 flush  in  1  synchronous FIFO clear, one-cycle pulse.
REQ-010 clear_overflow  in  1  synchronous clear of overflow_flag and drop_count.
REQ-011 out_ready  in  1  consumer accepts out_data when high with out_valid.
REQ-012 out_valid  out  1  head entry available.
REQ-013 out_data  out  12  head entry: bit 11 = alpha, bits 10:0 = sample.
REQ-014 fifo_level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 overflow_flag  out  1  sticky; set when a sample is dropped.
REQ-016 drop_count  out  8  saturating count of dropped samples.

Function
REQ-017 The block SHALL register enable_sampling_3M once (cap_strobe); a write request SHALL occur in the cycle when cap_strobe=1 and capture_en=1, sampling sample_in/alpha_in in that cycle, so the converter result updated on the strobe edge is the one stored.
REQ-018 capture_en SHALL be evaluated in the cap_strobe cycle only; toggling it between strobes SHALL have no effect.
REQ-019 The FIFO SHALL be first-word-fall-through: out_data SHALL present the head entry combinationally from storage, and out_valid SHALL equal (fifo_level != 0).
REQ-020 A read SHALL occur on a rising edge where out_valid=1 and out_ready=1; the head SHALL advance by one entry.
REQ-021 Write-to-out_valid latency SHALL be one clock: after a write into an empty FIFO, out_valid SHALL be 1 from the next cycle.
REQ-022 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Simultaneous read and write with 0 < level < DEPTH: both SHALL occur; level unchanged.
REQ-025 Write with level = DEPTH and a read in the same cycle: write SHALL be accepted; level stays DEPTH.
REQ-026 Write with level = DEPTH and no read: sample SHALL be dropped, storage unchanged, overflow_flag set to 1, drop_count incremented, saturating at 255.
REQ-027 Write with level = 0: no read occurs that cycle (out_valid=0); level becomes 1.
REQ-028 flush=1 SHALL, at that edge, set pointers and level to 0 and discard any same-cycle write and read; overflow_flag and drop_count SHALL be unaffected.
REQ-029 clear_overflow=1 SHALL clear overflow_flag and drop_count; if a drop occurs in the same cycle, the result SHALL be overflow_flag=1, drop_count=1.
REQ-030 flush and clear_overflow in the same cycle SHALL both take effect.

Reset
REQ-031 When reset=0: out_valid=0, out_data=0, fifo_level=0, overflow_flag=0, drop_count=0, pointers=0, cap_strobe=0; storage contents SHALL be don't-care but never observable while out_valid=0.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; after release, the first write SHALL land at pointer 0.
REQ-033 After reset release, the first enable_sampling_3M pulse SHALL produce a write exactly one cycle later if capture_en=1.

Verification
REQ-034 Strobe with sample_in=11'h3FF, alpha_in=1, capture_en=1, out_ready=0 -> one cycle after cap_strobe: out_valid=1, out_data=12'hBFF, fifo_level=1.
REQ-035 9 strobes, out_ready=0, DEPTH=8 -> fifo_level=8, overflow_flag=1, drop_count=1; draining yields the first 8 samples in order.
REQ-036 300 strobes into a full FIFO with no reads -> drop_count=255 (saturated); clear_overflow -> flag=0, count=0.
REQ-037 Full FIFO, out_ready=1 on the cap_strobe cycle -> write accepted, level stays 8, drop_count unchanged.
REQ-038 4 entries stored, flush coincident with cap_strobe -> fifo_level=0, out_valid=0 the next cycle; the next strobe writes at pointer 0.
REQ-039 reset pulsed low with 5 entries stored -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dogx_sample_buffer.sv
// dogx_sample_buffer
//   First-word-fall-through sample FIFO between the converter and its
//   consumer. enable_sampling_3M is registered once (cap_strobe). In the
//   cap_strobe cycle the converter word that changed on the strobe edge is
//   written as {alpha_in, sample_in}, provided capture_en is high. A sample
//   arriving at a full FIFO with no read in the same cycle is dropped. A drop
//   sets a sticky overflow flag and increments a saturating drop counter.
//
// Ports
//   CLK_24M            in   system clock (rising edge)
//   reset              in   async active-low reset
//   enable_sampling_3M in   sample strobe from the converter enable generator
//   sample_in[10:0]    in   converter word, two's complement
//   alpha_in           in   channel-select flag for sample_in
//   capture_en         in   capture enable, sampled in the cap_strobe cycle
//   flush              in   synchronous FIFO clear
//   clear_overflow     in   synchronous clear of overflow_flag/drop_count
//   out_ready          in   consumer accepts the head entry
//   out_valid          out  head entry available
//   out_data[11:0]     out  head entry {alpha, sample}
//   fifo_level         out  stored entry count, 0..DEPTH
//   overflow_flag      out  sticky drop indicator
//   drop_count[7:0]    out  saturating dropped-sample count
module dogx_sample_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 12
) (
  input  logic                     CLK_24M,
  input  logic                     reset,
  input  logic                     enable_sampling_3M,
  input  logic [10:0]              sample_in,
  input  logic                     alpha_in,
  input  logic                     capture_en,
  input  logic                     flush,
  input  logic                     clear_overflow,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow_flag,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic          cap_strobe_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic full, empty, wr_req, wr_en, rd_en, drop;

  assign full   = (level_q == (AW+1)'(DEPTH));
  assign empty  = (level_q == '0);
  assign wr_req = cap_strobe_q & capture_en;
  // flush discards both sides of any same-cycle transfer
  assign rd_en  = ~empty & out_ready & ~flush;
  // a full FIFO still takes the write when the head leaves in the same edge
  assign wr_en  = wr_req & (~full | rd_en) & ~flush;
  // a write discarded by flush is not an overflow
  assign drop   = wr_req & full & ~rd_en & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end

    // clear first so a same-cycle drop leaves flag=1, count=1
    if (clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
    end
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      cap_strobe_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      cap_strobe_q <= enable_sampling_3M;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  // storage is not reset; it is masked from out_data whenever the FIFO is empty
  always_ff @(posedge CLK_24M) begin
    if (wr_en) mem_q[wr_ptr_q] <= {alpha_in, sample_in};
  end

  assign out_valid     = ~empty;
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level    = level_q;
  assign overflow_flag = ovf_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_dogx_sample_buffer.sv
module tb_dogx_sample_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_sampling_3M = 1'b0;
  logic [10:0] sample_in = '0;
  logic        alpha_in = 1'b0;
  logic        capture_en = 1'b1;
  logic        flush = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] out_data;
  logic [3:0]  fifo_level;
  logic        overflow_flag;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dogx_sample_buffer #(.DEPTH(8), .DW(12)) dut (
    .CLK_24M(clk), .reset(reset), .enable_sampling_3M(enable_sampling_3M),
    .sample_in(sample_in), .alpha_in(alpha_in), .capture_en(capture_en),
    .flush(flush), .clear_overflow(clear_overflow), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .fifo_level(fifo_level),
    .overflow_flag(overflow_flag), .drop_count(drop_count)
  );

  // One strobe: pulse enable, then present the converter word (plus optional
  // ready/clear/flush) in the cap_strobe cycle; returns one cycle after the write.
  task automatic strobe(input logic [10:0] s, input logic a, input logic rdy,
                        input logic clr, input logic fl);
    @(negedge clk); enable_sampling_3M = 1'b1;
    @(negedge clk); enable_sampling_3M = 1'b0;
    sample_in = s; alpha_in = a; out_ready = rdy; clear_overflow = clr; flush = fl;
    @(negedge clk); out_ready = 1'b0; clear_overflow = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h exp 000", out_data); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_flag); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk); enable_sampling_3M = 1'b1;
    @(negedge clk); enable_sampling_3M = 1'b0; sample_in = 11'h3FF; alpha_in = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 12'hBFF) begin errors++; $display("FAIL single_data got %h exp BFF", out_data); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level got %0d exp 1", fifo_level); end
    sample_in = 11'h000; alpha_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_data !== 12'hBFF) begin errors++; $display("FAIL single_hold got %h exp BFF", out_data); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    checks++; if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got lvl %0d vld %0b exp 0 0", fifo_level, out_valid); end
  endtask

  task automatic test_capture_gate;
    // capture_en high around the strobe but low in the cap_strobe cycle
    @(negedge clk); enable_sampling_3M = 1'b1; capture_en = 1'b1;
    @(negedge clk); enable_sampling_3M = 1'b0; capture_en = 1'b0; sample_in = 11'h111;
    @(negedge clk); capture_en = 1'b1;
    @(negedge clk);
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL gate_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_overflow;
    logic [11:0] exp;
    for (int i = 0; i < 9; i++) strobe(11'(16 + i), i[0], 1'b0, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
    checks++; if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow_flag); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", drop_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = {i[0], 11'(16 + i)};
      checks++; if (out_data !== exp) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, out_data, exp); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 12'h000) begin errors++; $display("FAIL ovf_empty got vld %0b data %h exp 0 000", out_valid, out_data); end
    clear_overflow = 1'b1; @(negedge clk); clear_overflow = 1'b0;
    checks++; if (overflow_flag !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clear got %0b %0d exp 0 0", overflow_flag, drop_count); end
  endtask

  task automatic test_full_rw;
    logic [11:0] exp;
    for (int i = 0; i < 8; i++) strobe(11'(32 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(11'h055, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullrw_level got %0d exp 8", fifo_level); end
    checks++; if (drop_count !== 8'd0 || overflow_flag !== 1'b0) begin errors++; $display("FAIL fullrw_drop got %0d %0b exp 0 0", drop_count, overflow_flag); end
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      exp = (i == 8) ? 12'h855 : {1'b0, 11'(32 + i)};
      checks++; if (out_data !== exp) begin errors++; $display("FAIL fullrw_drain%0d got %h exp %h", i, out_data, exp); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fullrw_empty got %0d exp 0", fifo_level); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 8; i++) strobe(11'(64 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) strobe(11'h7AA, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d exp 255", drop_count); end
    checks++; if (out_data !== 12'h040) begin errors++; $display("FAIL sat_head got %h exp 040", out_data); end
    clear_overflow = 1'b1; @(negedge clk); clear_overflow = 1'b0;
    checks++; if (overflow_flag !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL sat_clear got %0b %0d exp 0 0", overflow_flag, drop_count); end
    // clear coincident with a drop
    strobe(11'h7BB, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow_flag !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL sat_clrdrop got %0b %0d exp 1 1", overflow_flag, drop_count); end
  endtask

  task automatic test_flush;
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    checks++; if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_level got %0d %0b exp 0 0", fifo_level, out_valid); end
    checks++; if (overflow_flag !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL flush_keepovf got %0b %0d exp 1 1", overflow_flag, drop_count); end
    for (int i = 0; i < 4; i++) strobe(11'(80 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(11'h0EE, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flushw_level got %0d %0b exp 0 0", fifo_level, out_valid); end
    strobe(11'h123, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 12'h923 || fifo_level !== 4'd1) begin errors++; $display("FAIL flush_next got %h %0d exp 923 1", out_data, fifo_level); end
    flush = 1'b1; clear_overflow = 1'b1; @(negedge clk); flush = 1'b0; clear_overflow = 1'b0;
    checks++; if (fifo_level !== 4'd0 || overflow_flag !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL flushclr got %0d %0b %0d exp 0 0 0", fifo_level, overflow_flag, drop_count); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) strobe(11'(96 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL arst_pre got %0d exp 5", fifo_level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 12'h000 || fifo_level !== 4'd0) begin errors++; $display("FAIL arst_now got %0b %h %0d exp 0 000 0", out_valid, out_data, fifo_level); end
    @(negedge clk); reset = 1'b1;
    strobe(11'h0AB, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 12'h0AB || fifo_level !== 4'd1) begin errors++; $display("FAIL arst_after got %h %0d exp 0AB 1", out_data, fifo_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_capture_gate();
    test_overflow();
    test_full_rw();
    test_saturate();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
